// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two client command ports and the SRAM controller command port.
// slave  : arbiter side (takes client requests, drives the controller).
// master : environment side (clients plus controller).
// Client N : cN_req/rw/addr/wdata in, cN_ack/rdata/rvalid out (arbiter view).
// Controller: sram_mem/rw/addr/wdata out, sram_ready/rdata in (arbiter view).
interface sram_port_arbiter_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
);
  logic          c0_req;
  logic          c0_rw;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata;
  logic          c0_ack;
  logic [DW-1:0] c0_rdata;
  logic          c0_rvalid;

  logic          c1_req;
  logic          c1_rw;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata;
  logic          c1_ack;
  logic [DW-1:0] c1_rdata;
  logic          c1_rvalid;

  logic          busy;

  logic          sram_mem;
  logic          sram_rw;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_ready;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  c0_req, c0_rw, c0_addr, c0_wdata,
    input  c1_req, c1_rw, c1_addr, c1_wdata,
    input  sram_ready, sram_rdata,
    output c0_ack, c0_rdata, c0_rvalid,
    output c1_ack, c1_rdata, c1_rvalid,
    output busy,
    output sram_mem, sram_rw, sram_addr, sram_wdata
  );

  modport master (
    output c0_req, c0_rw, c0_addr, c0_wdata,
    output c1_req, c1_rw, c1_addr, c1_wdata,
    output sram_ready, sram_rdata,
    input  c0_ack, c0_rdata, c0_rvalid,
    input  c1_ack, c1_rdata, c1_rvalid,
    input  busy,
    input  sram_mem, sram_rw, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-client round-robin arbiter in front of the asynchronous SRAM controller.
// Serialises one complete SRAM transaction at a time: grant in IDLE, hold mem
// for one accepted cycle in ISSUE, wait for the controller to return to idle in
// WAIT, then hand read data back to the owning client with a one-cycle rvalid.
// Ports:
//   clk   : system clock (shared with the controller)
//   reset : asynchronous, active-high
//   bus   : client command ports, busy, and controller command port (slave view)
// All outputs come straight from flops, except busy which decodes the state flop.
module sram_port_arbiter #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
) (
  input  logic              clk,
  input  logic              reset,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          sram_mem_q, sram_mem_d;
  logic          sram_rw_q, sram_rw_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [DW-1:0] sram_wdata_q, sram_wdata_d;
  logic          c0_ack_q, c0_ack_d;
  logic          c1_ack_q, c1_ack_d;
  logic          c0_rvalid_q, c0_rvalid_d;
  logic          c1_rvalid_q, c1_rvalid_d;
  logic [DW-1:0] c0_rdata_q, c0_rdata_d;
  logic [DW-1:0] c1_rdata_q, c1_rdata_d;

  logic any_req;
  logic winner;

  assign any_req = bus.c0_req | bus.c1_req;
  // On a tie the client that did not win last time goes; otherwise the lone requester.
  assign winner  = (bus.c0_req && bus.c1_req) ? ~last_grant_q : bus.c1_req;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    sram_mem_d   = sram_mem_q;
    sram_rw_d    = sram_rw_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    c0_ack_d     = 1'b0;
    c1_ack_d     = 1'b0;
    c0_rvalid_d  = 1'b0;
    c1_rvalid_d  = 1'b0;
    c0_rdata_d   = c0_rdata_q;
    c1_rdata_d   = c1_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d      = winner;
          last_grant_d = winner;
          sram_rw_d    = winner ? bus.c1_rw    : bus.c0_rw;
          sram_addr_d  = winner ? bus.c1_addr  : bus.c0_addr;
          sram_wdata_d = winner ? bus.c1_wdata : bus.c0_wdata;
          c0_ack_d     = ~winner;
          c1_ack_d     = winner;
          sram_mem_d   = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        // Controller only accepts mem while idle; keep asserting until it does.
        if (bus.sram_ready) begin
          sram_mem_d = 1'b0;
          state_d    = StWait;
        end
      end
      StWait: begin
        // First ready after acceptance means the op is done and read data is valid.
        if (bus.sram_ready) begin
          if (sram_rw_q) begin
            if (owner_q) begin
              c1_rdata_d  = bus.sram_rdata;
              c1_rvalid_d = 1'b1;
            end else begin
              c0_rdata_d  = bus.sram_rdata;
              c0_rvalid_d = 1'b1;
            end
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      sram_mem_q   <= 1'b0;
      sram_rw_q    <= 1'b1;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      c0_ack_q     <= 1'b0;
      c1_ack_q     <= 1'b0;
      c0_rvalid_q  <= 1'b0;
      c1_rvalid_q  <= 1'b0;
      c0_rdata_q   <= '0;
      c1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      sram_mem_q   <= sram_mem_d;
      sram_rw_q    <= sram_rw_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      c0_ack_q     <= c0_ack_d;
      c1_ack_q     <= c1_ack_d;
      c0_rvalid_q  <= c0_rvalid_d;
      c1_rvalid_q  <= c1_rvalid_d;
      c0_rdata_q   <= c0_rdata_d;
      c1_rdata_q   <= c1_rdata_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.sram_mem   = sram_mem_q;
  assign bus.sram_rw    = sram_rw_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.c0_ack     = c0_ack_q;
  assign bus.c1_ack     = c1_ack_q;
  assign bus.c0_rvalid  = c0_rvalid_q;
  assign bus.c1_rvalid  = c1_rvalid_q;
  assign bus.c0_rdata   = c0_rdata_q;
  assign bus.c1_rdata   = c1_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level model (slot timing + memory array).
module tb_sram_port_arbiter;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset;

  sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural SRAM + controller: accepts mem while idle, busy two cycles,
  // back to idle with registered read data on the third.
  logic [1:0]    ctl_cnt;
  logic          ctl_rw;
  logic [7:0]    ctl_addr;
  logic [DW-1:0] ctl_rdata;
  logic [DW-1:0] sram_mem_arr [256];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_cnt   <= 2'd0;
      ctl_rw    <= 1'b1;
      ctl_addr  <= 8'd0;
      ctl_rdata <= '0;
      for (int i = 0; i < 256; i++) sram_mem_arr[i] <= '0;
    end else if (ctl_cnt == 2'd0) begin
      if (bus.sram_mem) begin
        ctl_cnt  <= 2'd2;
        ctl_rw   <= bus.sram_rw;
        ctl_addr <= bus.sram_addr[7:0];
        if (!bus.sram_rw) sram_mem_arr[bus.sram_addr[7:0]] <= bus.sram_wdata;
      end
    end else begin
      ctl_cnt <= ctl_cnt - 2'd1;
      if (ctl_cnt == 2'd1 && ctl_rw) ctl_rdata <= sram_mem_arr[ctl_addr];
    end
  end

  assign bus.sram_ready = (ctl_cnt == 2'd0);
  assign bus.sram_rdata = ctl_rdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input int c, input logic req, input logic rw,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (c == 0) begin
      bus.c0_req = req; bus.c0_rw = rw; bus.c0_addr = addr; bus.c0_wdata = wd;
    end else begin
      bus.c1_req = req; bus.c1_rw = rw; bus.c1_addr = addr; bus.c1_wdata = wd;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive_c(0, 1'b0, 1'b1, '0, '0);
    drive_c(1, 1'b0, 1'b1, '0, '0);
    repeat (3) tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if ({bus.busy, bus.sram_mem, bus.sram_rw, bus.c0_ack, bus.c1_ack, bus.c0_rvalid,
         bus.c1_rvalid} !== 7'b0010000)
      $display("FAIL reset_ctrl: got %b want 0010000", {bus.busy, bus.sram_mem, bus.sram_rw,
               bus.c0_ack, bus.c1_ack, bus.c0_rvalid, bus.c1_rvalid});
    else passed++;
    total++;
    if (bus.sram_addr !== '0 || bus.sram_wdata !== '0)
      $display("FAIL reset_sram_bus: addr %h wdata %h want 0 0", bus.sram_addr, bus.sram_wdata);
    else passed++;
    total++;
    if (bus.c0_rdata !== '0 || bus.c1_rdata !== '0)
      $display("FAIL reset_rdata: c0 %h c1 %h want 0 0", bus.c0_rdata, bus.c1_rdata);
    else passed++;
    for (int k = 0; k < 20; k++) begin
      tick;
      total++;
      if (bus.sram_mem !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL idle_quiet: cycle %0d mem %b busy %b want 0 0", k, bus.sram_mem, bus.busy);
      else passed++;
    end
  endtask

  task automatic test_write;
    int n;
    int mem_seen;
    drive_c(0, 1'b1, 1'b0, 18'h00010, 16'hA5A5);
    tick;
    total++;
    if (bus.c0_ack !== 1'b1 || bus.c1_ack !== 1'b0)
      $display("FAIL write_ack: c0 %b c1 %b want 1 0", bus.c0_ack, bus.c1_ack);
    else passed++;
    total++;
    if (bus.sram_mem !== 1'b1 || bus.sram_rw !== 1'b0 || bus.sram_addr !== 18'h00010 ||
        bus.sram_wdata !== 16'hA5A5)
      $display("FAIL write_issue: mem %b rw %b addr %h wdata %h want 1 0 00010 a5a5",
               bus.sram_mem, bus.sram_rw, bus.sram_addr, bus.sram_wdata);
    else passed++;
    drive_c(0, 1'b0, 1'b0, '0, '0);
    tick;
    total++;
    if (bus.c0_ack !== 1'b0 || bus.sram_mem !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL write_wait: ack %b mem %b busy %b want 0 0 1", bus.c0_ack, bus.sram_mem,
               bus.busy);
    else passed++;
    n = 0;
    mem_seen = 0;
    while (bus.busy === 1'b1 && n < 10) begin
      tick;
      n++;
      if (bus.sram_mem === 1'b1) mem_seen++;
    end
    total++;
    if (n !== 3) $display("FAIL write_busy_drop: got %0d cycles want 3", n);
    else passed++;
    total++;
    if (mem_seen !== 0) $display("FAIL write_mem_once: extra mem cycles %0d want 0", mem_seen);
    else passed++;
  endtask

  task automatic test_read;
    drive_c(1, 1'b1, 1'b1, 18'h00010, 16'h0000);
    tick;
    total++;
    if (bus.c1_ack !== 1'b1 || bus.c0_ack !== 1'b0 || bus.sram_rw !== 1'b1)
      $display("FAIL read_ack: c1 %b c0 %b rw %b want 1 0 1", bus.c1_ack, bus.c0_ack, bus.sram_rw);
    else passed++;
    drive_c(1, 1'b0, 1'b1, '0, '0);
    for (int k = 2; k <= 5; k++) begin
      tick;
      total++;
      if (bus.c1_rvalid !== (k == 5) || bus.c0_rvalid !== 1'b0)
        $display("FAIL read_rvalid: cycle %0d c1 %b c0 %b want %b 0", k, bus.c1_rvalid,
                 bus.c0_rvalid, (k == 5));
      else passed++;
    end
    total++;
    if (bus.c1_rdata !== 16'hA5A5 || bus.c0_rdata !== 16'h0000)
      $display("FAIL read_data: c1 %h c0 %h want a5a5 0000", bus.c1_rdata, bus.c0_rdata);
    else passed++;
    tick;
    total++;
    if (bus.c1_rvalid !== 1'b0 || bus.c1_rdata !== 16'hA5A5)
      $display("FAIL read_hold: rvalid %b rdata %h want 0 a5a5", bus.c1_rvalid, bus.c1_rdata);
    else passed++;
  endtask

  task automatic test_both;
    logic          rw0 [2];
    logic          rw1 [2];
    logic [AW-1:0] ad0 [2];
    logic [AW-1:0] ad1 [2];
    logic [DW-1:0] wd0 [2];
    logic [DW-1:0] wd1 [2];
    int idx0, idx1, code, dbl, both, rv0_cnt, rv1_cnt;
    logic prev0, prev1;
    logic [DW-1:0] rv0_data, rv1_data;
    rw0[0] = 1'b0; ad0[0] = 18'h00030; wd0[0] = 16'h1234;
    rw0[1] = 1'b1; ad0[1] = 18'h00031; wd0[1] = 16'h0000;
    rw1[0] = 1'b0; ad1[0] = 18'h00031; wd1[0] = 16'hBEEF;
    rw1[1] = 1'b1; ad1[1] = 18'h00030; wd1[1] = 16'h0000;
    do_reset;
    idx0 = 0; idx1 = 0; code = 0; dbl = 0; both = 0; rv0_cnt = 0; rv1_cnt = 0;
    prev0 = 1'b0; prev1 = 1'b0; rv0_data = '0; rv1_data = '0;
    drive_c(0, 1'b1, rw0[0], ad0[0], wd0[0]);
    drive_c(1, 1'b1, rw1[0], ad1[0], wd1[0]);
    for (int k = 0; k < 40; k++) begin
      tick;
      if (bus.c0_ack === 1'b1 && bus.c1_ack === 1'b1) both++;
      if (bus.c0_ack === 1'b1) begin
        code = code * 10 + 1;
        if (prev0) dbl++;
        idx0++;
        if (idx0 < 2) drive_c(0, 1'b1, rw0[idx0], ad0[idx0], wd0[idx0]);
        else drive_c(0, 1'b0, 1'b1, '0, '0);
      end
      if (bus.c1_ack === 1'b1) begin
        code = code * 10 + 2;
        if (prev1) dbl++;
        idx1++;
        if (idx1 < 2) drive_c(1, 1'b1, rw1[idx1], ad1[idx1], wd1[idx1]);
        else drive_c(1, 1'b0, 1'b1, '0, '0);
      end
      prev0 = bus.c0_ack;
      prev1 = bus.c1_ack;
      if (bus.c0_rvalid === 1'b1) begin rv0_cnt++; rv0_data = bus.c0_rdata; end
      if (bus.c1_rvalid === 1'b1) begin rv1_cnt++; rv1_data = bus.c1_rdata; end
    end
    total++;
    if (code !== 1212) $display("FAIL both_order: got %0d want 1212 (1=c0,2=c1)", code);
    else passed++;
    total++;
    if (dbl !== 0 || both !== 0)
      $display("FAIL both_ack_pulse: double %0d simultaneous %0d want 0 0", dbl, both);
    else passed++;
    total++;
    if (rv0_cnt !== 1 || rv0_data !== 16'hBEEF)
      $display("FAIL both_c0_read: count %0d data %h want 1 beef", rv0_cnt, rv0_data);
    else passed++;
    total++;
    if (rv1_cnt !== 1 || rv1_data !== 16'h1234)
      $display("FAIL both_c1_read: count %0d data %h want 1 1234", rv1_cnt, rv1_data);
    else passed++;
  endtask

  task automatic test_hold;
    int c0_ack_cyc, c1_extra, rv_cyc;
    logic [DW-1:0] rv_data;
    c0_ack_cyc = -1; c1_extra = 0; rv_cyc = -1; rv_data = '0;
    drive_c(1, 1'b1, 1'b0, 18'h00040, 16'h5555);
    tick;
    total++;
    if (bus.c1_ack !== 1'b1) $display("FAIL hold_first_ack: got %b want 1", bus.c1_ack);
    else passed++;
    drive_c(0, 1'b1, 1'b1, 18'h00040, 16'h0000);
    tick;
    drive_c(1, 1'b0, 1'b0, '0, '0);
    if (bus.c1_ack === 1'b1) c1_extra++;
    for (int k = 3; k <= 15; k++) begin
      tick;
      if (bus.c1_ack === 1'b1) c1_extra++;
      if (bus.c0_ack === 1'b1) begin
        if (c0_ack_cyc < 0) c0_ack_cyc = k;
        drive_c(0, 1'b0, 1'b1, '0, '0);
      end
      if (bus.c0_rvalid === 1'b1) begin rv_cyc = k; rv_data = bus.c0_rdata; end
    end
    total++;
    if (c1_extra !== 0) $display("FAIL hold_single_ack: extra c1 acks %0d want 0", c1_extra);
    else passed++;
    total++;
    if (c0_ack_cyc !== 6) $display("FAIL hold_next_grant: c0 ack cycle %0d want 6", c0_ack_cyc);
    else passed++;
    total++;
    if (rv_cyc !== 10 || rv_data !== 16'h5555)
      $display("FAIL hold_read: rvalid cycle %0d data %h want 10 5555", rv_cyc, rv_data);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int rv_seen;
    int rv_cyc;
    drive_c(0, 1'b1, 1'b1, 18'h00040, 16'h0000);
    tick;
    drive_c(0, 1'b0, 1'b1, '0, '0);
    tick;
    tick;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.sram_mem, bus.sram_rw, bus.c0_ack, bus.c1_ack, bus.c0_rvalid,
         bus.c1_rvalid} !== 7'b0010000 || bus.sram_addr !== '0 || bus.c0_rdata !== '0)
      $display("FAIL midreset_async: ctrl %b addr %h rdata %h want 0010000 0 0",
               {bus.busy, bus.sram_mem, bus.sram_rw, bus.c0_ack, bus.c1_ack, bus.c0_rvalid,
                bus.c1_rvalid}, bus.sram_addr, bus.c0_rdata);
    else passed++;
    rv_seen = 0;
    tick;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (bus.c0_rvalid === 1'b1 || bus.c1_rvalid === 1'b1) rv_seen++;
    end
    total++;
    if (rv_seen !== 0 || bus.busy !== 1'b0)
      $display("FAIL midreset_no_rvalid: rvalids %0d busy %b want 0 0", rv_seen, bus.busy);
    else passed++;
    drive_c(1, 1'b1, 1'b0, 18'h00050, 16'h7E7E);
    tick;
    drive_c(1, 1'b0, 1'b0, '0, '0);
    repeat (4) tick;
    drive_c(0, 1'b1, 1'b1, 18'h00050, 16'h0000);
    rv_cyc = -1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (bus.c0_ack === 1'b1) drive_c(0, 1'b0, 1'b1, '0, '0);
      if (bus.c0_rvalid === 1'b1 && rv_cyc < 0) rv_cyc = k;
    end
    total++;
    if (rv_cyc !== 5 || bus.c0_rdata !== 16'h7E7E)
      $display("FAIL midreset_fresh_read: rvalid cycle %0d data %h want 5 7e7e", rv_cyc,
               bus.c0_rdata);
    else passed++;
  endtask

  // Randomized traffic against a slot model: the arbiter is free from cycle
  // free_at; a grant at cycle g shows ack at g+1, mem at g+1, busy g+1..g+4,
  // rvalid at g+5, and frees the arbiter again at g+5.
  task automatic test_random(input int cycles);
    logic [DW-1:0] ref_mem [256];
    logic          pend [2];
    logic          p_rw [2];
    logic [7:0]    p_addr [2];
    logic [DW-1:0] p_wd [2];
    int            ack_at [2];
    int            rv_at [2];
    logic [DW-1:0] rv_data [2];
    logic [DW-1:0] exp_rdata [2];
    logic          g_rw;
    logic [7:0]    g_addr;
    logic [DW-1:0] g_wd;
    int cyc, free_at, last, w, grant_at;
    logic e_mem, e_busy;
    do_reset;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; p_rw[i] = 1'b1; p_addr[i] = '0; p_wd[i] = '0;
      ack_at[i] = -1; rv_at[i] = -1; rv_data[i] = '0; exp_rdata[i] = '0;
    end
    g_rw = 1'b1; g_addr = '0; g_wd = '0;
    cyc = 0; free_at = 0; last = 1; grant_at = -100;
    for (int k = 0; k < cycles; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (ack_at[i] == cyc) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]   = 1'b1;
          p_rw[i]   = 1'($urandom_range(0, 1));
          p_addr[i] = 8'($urandom_range(0, 7));
          p_wd[i]   = 16'($urandom);
        end
        drive_c(i, pend[i], p_rw[i], AW'(p_addr[i]), p_wd[i]);
      end
      if (cyc >= free_at && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
        last = w;
        ack_at[w] = cyc + 1;
        grant_at = cyc;
        free_at = cyc + 5;
        g_rw = p_rw[w]; g_addr = p_addr[w]; g_wd = p_wd[w];
        if (p_rw[w]) begin
          rv_at[w] = cyc + 5;
          rv_data[w] = ref_mem[p_addr[w]];
        end else begin
          ref_mem[p_addr[w]] = p_wd[w];
        end
      end
      tick;
      cyc++;
      for (int i = 0; i < 2; i++) if (rv_at[i] == cyc) exp_rdata[i] = rv_data[i];
      e_mem  = (cyc == grant_at + 1);
      e_busy = (cyc > grant_at && cyc < grant_at + 5);
      total++;
      if (bus.c0_ack !== (ack_at[0] == cyc) || bus.c1_ack !== (ack_at[1] == cyc))
        $display("FAIL rand_ack: cycle %0d got %b%b want %b%b", cyc, bus.c0_ack, bus.c1_ack,
                 (ack_at[0] == cyc), (ack_at[1] == cyc));
      else passed++;
      total++;
      if (bus.c0_rvalid !== (rv_at[0] == cyc) || bus.c1_rvalid !== (rv_at[1] == cyc))
        $display("FAIL rand_rvalid: cycle %0d got %b%b want %b%b", cyc, bus.c0_rvalid,
                 bus.c1_rvalid, (rv_at[0] == cyc), (rv_at[1] == cyc));
      else passed++;
      total++;
      if (bus.c0_rdata !== exp_rdata[0] || bus.c1_rdata !== exp_rdata[1])
        $display("FAIL rand_rdata: cycle %0d got %h %h want %h %h", cyc, bus.c0_rdata,
                 bus.c1_rdata, exp_rdata[0], exp_rdata[1]);
      else passed++;
      total++;
      if (bus.sram_mem !== e_mem || bus.busy !== e_busy)
        $display("FAIL rand_mem_busy: cycle %0d got %b %b want %b %b", cyc, bus.sram_mem,
                 bus.busy, e_mem, e_busy);
      else passed++;
      if (e_mem) begin
        total++;
        if (bus.sram_rw !== g_rw || bus.sram_addr !== AW'(g_addr) ||
            (!g_rw && bus.sram_wdata !== g_wd))
          $display("FAIL rand_cmd: cycle %0d got rw %b addr %h wdata %h want %b %h %h", cyc,
                   bus.sram_rw, bus.sram_addr, bus.sram_wdata, g_rw, g_addr, g_wd);
        else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset;
    test_write;
    test_read;
    test_both;
    test_hold;
    test_reset_mid;
    test_random(400);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-client round-robin arbiter for the 16-bit asynchronous SRAM controller. It sits between two system masters (for example a video fetch engine and a CPU bus bridge) and the controller's single mem/rw/addr/data_f2s/ready command port. It serialises one complete SRAM transaction at a time and returns read data to the owning client with a one-cycle valid pulse.

## Interface
- AW, 18, address width; matches the controller addr.
- DW, 16, data width; matches the controller data ports.

- clk  in  1  system clock; same clock as the SRAM controller.
- reset  in  1  asynchronous, active-high; clock clk.
- c0_req, c1_req  in  1 each  client command request; held with fields stable until that client's ack.
- c0_rw, c1_rw  in  1 each  1 = read, 0 = write (controller polarity).
- c0_addr, c1_addr  in  AW each  word address.
- c0_wdata, c1_wdata  in  DW each  write data; ignored for reads.
- c0_ack, c1_ack  out  1 each  one-cycle pulse: the command was latched.
- c0_rdata, c1_rdata  out  DW each  last read data for that client; held between reads.
- c0_rvalid, c1_rvalid  out  1 each  one-cycle pulse: cN_rdata is updated.
- busy  out  1  high in every state except IDLE.
- sram_mem  out  1  controller mem.
- sram_rw  out  1  controller rw.
- sram_addr  out  AW  controller addr.
- sram_wdata  out  DW  controller data_f2s.
- sram_ready  in  1  controller ready; combinationally high only while the controller is idle.
- sram_rdata  in  DW  controller registered read data (data_s2f_r).

## Operation
- All sram_* outputs, acks, rvalids, and rdata are registered. There is no combinational path from client inputs to the controller.
- Reset values:
  - sram_mem = 0, sram_rw = 1, sram_addr = 0, sram_wdata = 0.
  - c0/c1_ack = 0, c0/c1_rvalid = 0, c0/c1_rdata = 0, busy = 0.
  - state = IDLE, owner = 0, last_grant = 1, so client 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant that client.
  - Both requesting: grant the client that is not last_grant.
  - On grant: latch the winner's rw/addr/wdata into sram_rw/sram_addr/sram_wdata; set owner and last_grant to the winner; pulse the winner's ack next cycle; go to ISSUE.
- ISSUE:
  - sram_mem = 1.
  - sram_ready = 1: the controller accepts this cycle; sram_mem clears at the next edge; go to WAIT.
  - sram_ready = 0: hold sram_mem and stay in ISSUE. This is defensive only and does not occur in normal flow.
- WAIT:
  - sram_mem = 0.
  - On the first cycle with sram_ready = 1:
    - If the op is a read, capture sram_rdata into the owner's rdata and pulse the owner's rvalid next cycle.
    - Go to IDLE (read or write).
- Requests arriving outside IDLE are not sampled; they wait for the next IDLE cycle.
- A client's req still high in the cycle its ack is visible is ignored, because the arbiter is not in IDLE. Clients drop req (or present a new command) after seeing ack.
- The non-owner's ack, rvalid, and rdata are never disturbed.
- sram_rw/addr/wdata hold their last values while in IDLE.

## Timing
- Cycle T: IDLE, grant.
- T+1: ISSUE, sram_mem = 1, ack high; controller idle → accepts.
- T+2, T+3: WAIT; controller in wr1/wr2 or rd1/rd2; sram_ready = 0.
- T+4: WAIT; controller back in idle, sram_ready = 1, sram_rdata valid; captured at the end of T+4.
- T+5: IDLE; owner rvalid = 1 (reads) and rdata updated.
- Write completion needs no client signal.
- Request-to-ack latency: 1 cycle.
- Request-to-rvalid latency: 5 cycles.
- Back-to-back throughput: one transaction per 5 cycles. A grant may occur in the same cycle that rvalid is shown.
- With both clients continuously requesting, grants alternate 0,1,0,1,…
- A single client continuously requesting gets every slot.
- Reset mid-transaction:
  - All state returns to the reset values immediately.
  - The aborted op produces no rvalid.
  - The controller shares this reset, so no SRAM op is left pending.

## Test plan
- Reset then idle: all outputs at reset values, sram_mem = 0 for 20 cycles, busy = 0.
- Client 0 writes 0xA5A5 to 0x00010:
  - c0_ack one cycle after req.
  - sram_mem high exactly one cycle with rw = 0, addr = 0x00010, wdata = 0xA5A5.
  - busy drops after sram_ready returns.
- Client 1 reads 0x00010 from a behavioural SRAM plus controller model: c1_rvalid pulses 5 cycles after req with c1_rdata = 0xA5A5; c0_rdata/c0_rvalid remain unchanged.
- Both clients request in the same cycle from reset:
  - Grant order 0,1,0,1 over four transactions.
  - Each ack is a single pulse.
  - Read data returns to the correct client.
- Client 1 holds req through its own ack cycle while client 0 requests: exactly one c1_ack; next grant goes to client 0.
- Reset asserted during WAIT of a read: no rvalid occurs, outputs return to reset values asynchronously, and a fresh read after reset completes normally.
